// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter that gives NREQ trace requesters one shared cache lookup port and runs each miss through writeback and fill.
// Optional per-requester grant/wait counters are enabled with CACHE_REQ_ARBITER_STATS_EN.
module cache_req_arbiter #(
    parameter int NREQ         = 2,
    parameter int ADDRESS_SIZE = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ-1:0]              req_rw,
    input  logic [NREQ*ADDRESS_SIZE-1:0] req_addr,
    output logic [NREQ-1:0]              req_ready,
    output logic [NREQ-1:0]              done,
    output logic                         cache_valid,
    output logic                         cache_rw,
    output logic [ADDRESS_SIZE-1:0]      cache_addr,
    input  logic                         cache_hit,
    input  logic                         cache_wb,
    output logic                         mem_req,
    output logic                         mem_wr,
    input  logic                         mem_ack,
    output logic                         busy
`ifdef CACHE_REQ_ARBITER_STATS_EN
    ,
    output logic [NREQ*32-1:0]           grant_cnt,
    output logic [NREQ*32-1:0]           wait_cnt
`endif
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESPOND} state_t;

    state_t                  state_reg, state_next;
    logic [PTR_W-1:0]        rr_ptr_reg, rr_ptr_next;
    logic [PTR_W-1:0]        owner_reg, owner_next;
    logic                    rw_reg, rw_next;
    logic [ADDRESS_SIZE-1:0] addr_reg, addr_next;
    logic                    gap_reg, gap_next;
    logic [PTR_W-1:0]        grant_idx;
    logic                    grant_found;
    logic [ADDRESS_SIZE-1:0] addr_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr
            assign addr_arr[gi] = req_addr[gi*ADDRESS_SIZE +: ADDRESS_SIZE];
        end
    endgenerate

    // First valid requester at or above rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grant_found && req_valid[PTR_W'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        owner_next  = owner_reg;
        rw_next     = rw_reg;
        addr_next   = addr_reg;
        gap_next    = 1'b0;
        req_ready   = '0;
        done        = '0;
        cache_valid = 1'b0;
        mem_req     = 1'b0;
        mem_wr      = 1'b0;
        busy        = (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                if (grant_found && reset_n) begin
                    req_ready   = NREQ'(1) << grant_idx;
                    owner_next  = grant_idx;
                    rw_next     = req_rw[grant_idx];
                    addr_next   = addr_arr[grant_idx];
                    rr_ptr_next = (grant_idx == PTR_W'(NREQ-1)) ? '0 : grant_idx + PTR_W'(1);
                    state_next  = LOOKUP;
                end
            end
            LOOKUP: begin
                cache_valid = 1'b1;
                if (cache_hit)     state_next = RESPOND;
                else if (cache_wb) state_next = WRITEBACK;
                else               state_next = FILL;
            end
            WRITEBACK: begin
                mem_req = 1'b1;
                mem_wr  = 1'b1;
                if (mem_ack) begin
                    state_next = FILL;
                    gap_next   = 1'b1;
                end
            end
            FILL: begin
                // First FILL cycle after a writeback keeps mem_req low so the request visibly drops.
                mem_req = !gap_reg;
                if (!gap_reg && mem_ack) state_next = RESPOND;
            end
            RESPOND: begin
                done       = NREQ'(1) << owner_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= '0;
            owner_reg  <= '0;
            rw_reg     <= 1'b0;
            addr_reg   <= '0;
            gap_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            owner_reg  <= owner_next;
            rw_reg     <= rw_next;
            addr_reg   <= addr_next;
            gap_reg    <= gap_next;
        end
    end

    assign cache_rw   = rw_reg;
    assign cache_addr = addr_reg;

`ifdef CACHE_REQ_ARBITER_STATS_EN
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_stats
            logic [31:0] grant_cnt_reg;
            logic [31:0] wait_cnt_reg;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    grant_cnt_reg <= '0;
                    wait_cnt_reg  <= '0;
                end else begin
                    if (req_ready[gi])                  grant_cnt_reg <= grant_cnt_reg + 32'd1;
                    if (req_valid[gi] && !req_ready[gi]) wait_cnt_reg <= wait_cnt_reg + 32'd1;
                end
            end
            assign grant_cnt[gi*32 +: 32] = grant_cnt_reg;
            assign wait_cnt[gi*32 +: 32]  = wait_cnt_reg;
        end
    endgenerate
`endif

endmodule

// File: doc/cache_req_arbiter.md
# cache_req_arbiter

Shares one cacheSim-style lookup port among NREQ trace requesters and sequences each miss through optional victim writeback and line fill against a handshaked memory model. It sits between the trace drivers and the cache model. It guarantees one outstanding cache transaction at a time, with round-robin fairness and a per-request completion pulse.

## Interface

- NREQ, 2, number of requesters (2..8)
- ADDRESS_SIZE, 16, byte-address width
- clk  in  1  rising-edge clock; one clock domain
- reset_n  in  1  reset, asynchronous and active-low
- req_valid  in  NREQ  request pending per requester; held until accepted
- req_rw  in  NREQ  0 = read, 1 = write
- req_addr  in  NREQ*ADDRESS_SIZE  requester i uses bits [i*ADDRESS_SIZE +: ADDRESS_SIZE]
- req_ready  out  NREQ  one-hot accept strobe
- done  out  NREQ  one-cycle completion pulse to the granted requester
- cache_valid  out  1  lookup strobe to the cache
- cache_rw  out  1  latched rw
- cache_addr  out  ADDRESS_SIZE  latched address
- cache_hit  in  1  combinational hit result, sampled while cache_valid is high
- cache_wb  in  1  victim valid and dirty, sampled while cache_valid is high
- mem_req  out  1  memory request, level signal
- mem_wr  out  1  1 = writeback, 0 = fill
- mem_ack  in  1  memory completion, one cycle
- busy  out  1  state is not IDLE

## Operation

FSM states: IDLE, LOOKUP, WRITEBACK, FILL, RESPOND.

- **IDLE**
  - req_ready is combinational: bit g is high when g is the granted requester.
  - Grant g is the first requester with req_valid set, searching upward from rr_ptr with wrap.
  - On accept, latch req_rw[g] and the req_addr slice into cache_rw and cache_addr, record g, set rr_ptr = (g+1) mod NREQ, and go to LOOKUP.
  - With no req_valid bits set, stay in IDLE and leave rr_ptr unchanged.
- **LOOKUP**
  - Assert cache_valid for exactly one cycle and sample cache_hit and cache_wb.
  - hit goes to RESPOND.
  - miss with cache_wb set goes to WRITEBACK.
  - miss with cache_wb clear goes to FILL.
- **WRITEBACK**: hold mem_req=1, mem_wr=1. On mem_ack, go to FILL.
- **FILL**: hold mem_req=1, mem_wr=0. On mem_ack, go to RESPOND.
- **RESPOND**: pulse done[g] and go to IDLE.
- mem_ack is ignored in IDLE, LOOKUP and RESPOND.
- mem_req drops in the cycle after mem_ack. Between WRITEBACK and FILL it falls for at least one cycle.
- cache_addr and cache_rw hold their values from accept through RESPOND.
- A requester whose req_valid is still high in RESPOND is treated as a new request. It can win in the next IDLE cycle, subject to rr_ptr.
- A req_valid deassertion before accept is legal and is not recorded.

## Timing

- Reset values: state IDLE, rr_ptr 0, all outputs 0, latched address and rw 0.
- Reset is asynchronous at any point. An in-flight mem_req drops immediately and the pending request is discarded without a done pulse.
- Accept edge is cycle 0. The number of cycles from accept to the done pulse:
  - hit: done in cycle 2; the next accept is possible in cycle 3.
  - clean miss: 2 + F cycles, where F is the number of cycles from entering FILL to mem_ack, with F ≥ 1.
  - dirty miss: 2 + W + 1 + F cycles, where W is the WRITEBACK wait and the extra cycle is the mem_req gap.
- Round robin: no requester waits more than NREQ-1 other transactions.

## Configuration

- Macro CACHE_REQ_ARBITER_STATS_EN.
- **Defined**:
  - Adds output grant_cnt, NREQ*32 bits, one 32-bit counter per requester, incremented on accept.
  - Adds output wait_cnt, NREQ*32 bits, incremented each cycle requester i has req_valid high and req_ready low.
  - Counters wrap at 2^32, and all counters reset to 0.
- **Undefined**: these ports and counters do not exist, and arbiter behaviour is identical.

## Test plan

- Reset then a single read hit from requester 0 at address 0x1230 → req_ready[0] in cycle 0, cache_valid in cycle 1 with cache_addr = 0x1230 and cache_rw = 0, done[0] in cycle 2, busy low in cycle 3.
- Write from requester 1 with a clean miss and mem_ack 3 cycles after FILL entry → mem_wr stays 0 throughout, done[1] at cycle 5, exactly one mem_req episode.
- Read with a dirty miss, W = 2 and F = 2 → mem_wr=1 episode, a 1-cycle mem_req gap, a mem_wr=0 episode, and done at cycle 7.
- Requesters 0 and 1 hold req_valid continuously for 6 transactions, all hits → grants alternate 0,1,0,1,0,1. With the stats macro defined, grant_cnt = 3 each.
- reset_n pulled low during FILL, then released → mem_req low asynchronously, no done pulse, rr_ptr = 0, next grant goes to requester 0.
- Stray mem_ack in IDLE and LOOKUP → no state change and no done pulse. A request with req_valid dropped before accept produces no transaction.
